// File: rtl/tx_flow_arbiter.sv
// Transmit-side arbiter: drains two source FIFOs round-robin into the downstream link FIFO
// under credit-based flow control, with a fixed two-clock pop-to-write pipeline.
module tx_flow_arbiter #(
   parameter int data_width   = 6,
   parameter int credit_width = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init,
   input  logic [credit_width-1:0] umbral_credit,
   input  logic [data_width-1:0]   D0_data,
   input  logic [data_width-1:0]   D1_data,
   input  logic                    empty_D0,
   input  logic                    empty_D1,
   input  logic                    pause,
   input  logic                    credit_return,
   output logic                    D0_pop,
   output logic                    D1_pop,
   output logic [data_width-1:0]   data_out,
   output logic                    wr_enable,
   output logic [credit_width-1:0] credits,
   output logic                    idle_out,
   output logic                    active_out,
   output logic                    error_out
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_INIT,
      ST_IDLE,
      ST_ACTIVE,
      ST_ERROR
   } state_t;

   localparam logic [credit_width-1:0] CREDIT_ONE = credit_width'(1);

   state_t                  state_reg, state_next;
   logic [credit_width-1:0] credits_reg, credits_next;
   logic [credit_width-1:0] limit_reg, limit_next;
   logic                    last_d0_reg, last_d0_next;
   logic                    stage_valid_reg;
   logic                    stage_src_reg;
   logic [data_width-1:0]   data_out_reg;
   logic                    wr_enable_reg;
   logic                    idle_reg, active_reg, error_reg;

   logic grant_d0, grant_d1, grant;
   logic overflow;
   logic live_next;

   // Round-robin grant; last_d0_reg == 0 means D1 was served last, so D0 wins after reset.
   always_comb begin
      grant_d0 = 1'b0;
      grant_d1 = 1'b0;
      if (state_reg == ST_ACTIVE && !pause && credits_reg != '0) begin
         if (!empty_D0 && !empty_D1) begin
            grant_d0 = !last_d0_reg;
            grant_d1 = last_d0_reg;
         end else begin
            grant_d0 = !empty_D0;
            grant_d1 = !empty_D1;
         end
      end
      grant = grant_d0 | grant_d1;
   end

   always_comb begin
      state_next   = state_reg;
      credits_next = credits_reg;
      limit_next   = limit_reg;
      last_d0_next = grant ? grant_d0 : last_d0_reg;
      overflow     = 1'b0;
      case (state_reg)
         ST_RESET: state_next = ST_INIT;
         ST_INIT: begin
            credits_next = umbral_credit;
            limit_next   = umbral_credit;
            if (init)
               state_next = (umbral_credit != '0) ? ST_IDLE : ST_ERROR;
         end
         ST_IDLE, ST_ACTIVE: begin
            if (grant && !credit_return) begin
               credits_next = credits_reg - CREDIT_ONE;
            end else if (credit_return && !grant) begin
               if (credits_reg == limit_reg)
                  overflow = 1'b1;
               else
                  credits_next = credits_reg + CREDIT_ONE;
            end
            if (overflow)
               state_next = ST_ERROR;
            else if (state_reg == ST_IDLE && !(empty_D0 && empty_D1))
               state_next = ST_ACTIVE;
            else if (state_reg == ST_ACTIVE && empty_D0 && empty_D1 && !stage_valid_reg)
               state_next = ST_IDLE;
         end
         default: state_next = ST_ERROR;
      endcase
      live_next = (state_next == ST_IDLE) || (state_next == ST_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= ST_RESET;
         credits_reg     <= '0;
         limit_reg       <= '0;
         last_d0_reg     <= 1'b0;
         stage_valid_reg <= 1'b0;
         stage_src_reg   <= 1'b0;
         data_out_reg    <= '0;
         wr_enable_reg   <= 1'b0;
         idle_reg        <= 1'b0;
         active_reg      <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         credits_reg     <= credits_next;
         limit_reg       <= limit_next;
         last_d0_reg     <= last_d0_next;
         stage_valid_reg <= grant;
         stage_src_reg   <= grant_d1;
         // A word in flight is dropped if this edge takes the block into ERROR.
         wr_enable_reg   <= stage_valid_reg && live_next;
         if (stage_valid_reg && live_next)
            data_out_reg <= stage_src_reg ? D1_data : D0_data;
         idle_reg        <= (state_next == ST_IDLE);
         active_reg      <= (state_next == ST_ACTIVE);
         error_reg       <= (state_next == ST_ERROR);
      end
   end

   assign D0_pop     = grant_d0;
   assign D1_pop     = grant_d1;
   assign data_out   = data_out_reg;
   assign wr_enable  = wr_enable_reg;
   assign credits    = credits_reg;
   assign idle_out   = idle_reg;
   assign active_out = active_reg;
   assign error_out  = error_reg;

endmodule

// File: tb/tb_tx_flow_arbiter.sv
// Randomized bench for tx_flow_arbiter: bench-owned FIFOs plus a transaction-level model
// (mode, credit arithmetic, queue of scheduled writes) compared every cycle.
module tb_tx_flow_arbiter;
   localparam int DW = 6;
   localparam int CW = 4;
   localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

   logic          clk = 1'b0;
   logic          reset, init, empty_D0, empty_D1, pause, credit_return;
   logic [CW-1:0] umbral_credit, credits;
   logic [DW-1:0] D0_data, D1_data, data_out;
   logic          D0_pop, D1_pop, wr_enable, idle_out, active_out, error_out;
   logic          pop0_q, pop1_q;

   always #5 clk = ~clk;

   tx_flow_arbiter #(.data_width(DW), .credit_width(CW)) dut (
      .clk(clk), .reset(reset), .init(init), .umbral_credit(umbral_credit),
      .D0_data(D0_data), .D1_data(D1_data), .empty_D0(empty_D0), .empty_D1(empty_D1),
      .pause(pause), .credit_return(credit_return), .D0_pop(D0_pop), .D1_pop(D1_pop),
      .data_out(data_out), .wr_enable(wr_enable), .credits(credits),
      .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
   );

   // The source FIFOs act on the pop strobes seen at the clock edge.
   always @(posedge clk) begin
      pop0_q <= D0_pop;
      pop1_q <= D1_pop;
   end

   typedef struct {
      int            due;
      logic [DW-1:0] val;
   } wr_t;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   wr_t           pending[$];

   int            tests_run = 0;
   int            tests_failed = 0;
   int            cyc = 0;
   int            m_mode = M_RESET;
   int            m_credits = 0;
   int            m_limit = 0;
   bit            m_last_d1 = 1'b1;
   logic [DW-1:0] m_data = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic run_cycle(input bit rst, input bit ini, input int umb, input bit pse,
                            input bit ret, input bit push0, input bit push1);
      bit g0, g1, e0, e1, exp_wr, ovf, busy;
      @(negedge clk);
      if (pop0_q === 1'b1 && q0.size() > 0) D0_data = q0.pop_front();
      else D0_data = DW'($urandom);
      if (pop1_q === 1'b1 && q1.size() > 0) D1_data = q1.pop_front();
      else D1_data = DW'($urandom);
      if (push0 && q0.size() < 8) q0.push_back(DW'($urandom));
      if (push1 && q1.size() < 8) q1.push_back(DW'($urandom));
      e0 = (q0.size() == 0);
      e1 = (q1.size() == 0);
      empty_D0      = e0;
      empty_D1      = e1;
      reset         = rst;
      init          = ini;
      umbral_credit = CW'(umb);
      pause         = pse;
      credit_return = ret;
      #1;

      exp_wr = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
         exp_wr = 1'b1;
         m_data = pending[0].val;
         void'(pending.pop_front());
         $display("[TB] cyc %0d write 0x%02h", cyc, m_data);
      end
      check_eq("wr_enable", 32'(wr_enable), 32'(exp_wr));
      check_eq("data_out", 32'(data_out), 32'(m_data));
      check_eq("credits", 32'(credits), 32'(m_credits));
      check_eq("idle_out", 32'(idle_out), 32'(m_mode == M_IDLE));
      check_eq("active_out", 32'(active_out), 32'(m_mode == M_ACTIVE));
      check_eq("error_out", 32'(error_out), 32'(m_mode == M_ERROR));

      g0 = 1'b0;
      g1 = 1'b0;
      if (m_mode == M_ACTIVE && !pse && m_credits != 0) begin
         if (!e0 && !e1) begin
            if (m_last_d1) g0 = 1'b1;
            else g1 = 1'b1;
         end else if (!e0) g0 = 1'b1;
         else if (!e1) g1 = 1'b1;
      end
      check_eq("D0_pop", 32'(D0_pop), 32'(g0));
      check_eq("D1_pop", 32'(D1_pop), 32'(g1));

      // Advance the model across the coming clock edge.
      if (!rst) begin
         m_mode    = M_RESET;
         m_credits = 0;
         m_limit   = 0;
         m_last_d1 = 1'b1;
         m_data    = '0;
         pending.delete();
      end else begin
         case (m_mode)
            M_RESET: m_mode = M_INIT;
            M_INIT: begin
               m_credits = umb;
               m_limit   = umb;
               if (ini) m_mode = (umb != 0) ? M_IDLE : M_ERROR;
            end
            M_IDLE, M_ACTIVE: begin
               ovf  = ret && !(g0 || g1) && (m_credits == m_limit);
               busy = (pending.size() > 0);
               if (!ovf) m_credits = m_credits - ((g0 || g1) ? 1 : 0) + (ret ? 1 : 0);
               if (g0) pending.push_back(wr_t'{due: cyc + 2, val: q0[0]});
               if (g1) pending.push_back(wr_t'{due: cyc + 2, val: q1[0]});
               if (g0 || g1) m_last_d1 = g1;
               if (ovf) begin
                  m_mode = M_ERROR;
                  pending.delete();
               end else if (m_mode == M_IDLE && !(e0 && e1)) m_mode = M_ACTIVE;
               else if (m_mode == M_ACTIVE && e0 && e1 && !busy) m_mode = M_IDLE;
            end
            default: ;
         endcase
      end
      cyc++;
   endtask

   initial begin
      int umb, len, kind;
      bit rst, pse, ret, p0, p1, drain;
      reset = 1'b0; init = 1'b0; umbral_credit = '0; pause = 1'b0; credit_return = 1'b0;
      empty_D0 = 1'b1; empty_D1 = 1'b1; D0_data = '0; D1_data = '0;
      for (int ep = 0; ep < 12; ep++) begin
         kind = ep % 4;
         repeat (2 + $urandom % 3)
            run_cycle(1'b0, 1'($urandom % 2), $urandom % 16, 1'b0, 1'($urandom % 2), 1'b0, 1'b0);
         umb = (ep == 4) ? 0 : 1 + $urandom % 15;
         repeat (2) run_cycle(1'b1, 1'b0, $urandom % 16, 1'b0, 1'b0, 1'b0, 1'b0);
         run_cycle(1'b1, 1'b1, umb, 1'b0, 1'b0, 1'b0, 1'b0);
         len = 100 + $urandom % 60;
         for (int i = 0; i < len; i++) begin
            drain = (kind == 2) && (i >= len / 2) && (m_mode != M_ERROR);
            pse   = (kind == 3) ? 1'($urandom % 2) : ($urandom % 6 == 0);
            ret   = drain ? 1'b1 : ((m_credits < m_limit) && ($urandom % 3 == 0));
            p0    = !drain && ($urandom % 5 < 2);
            p1    = !drain && ($urandom % 5 < 2);
            rst   = !((kind == 1) && (i == len / 2));
            run_cycle(rst, 1'($urandom % 2), $urandom % 16, pse, ret, p0, p1);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tx_flow_arbiter.md
Name: tx_flow_arbiter

Overview:
- Transmit-side counterpart of the transaction-layer receive logic.
- Drains two source FIFOs (D0, D1) by round-robin and writes each word into the downstream link FIFO (`data_out` / `wr_enable`).
- Observes credit-based flow control, with the credit limit programmed during INIT.
- Reports IDLE / ACTIVE / ERROR status in the same style as the receive path.

Parameters:
- data_width, 6, width of every data word.
- credit_width, 4, width of the credit counter and of the threshold input.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- init  in  1  high = leave INIT with the current threshold.
- umbral_credit  in  credit_width  credit limit, latched in INIT.
- D0_data  in  data_width  D0 FIFO read data, valid the cycle after D0_pop.
- D1_data  in  data_width  D1 FIFO read data, valid the cycle after D1_pop.
- empty_D0  in  1  D0 FIFO empty.
- empty_D1  in  1  D1 FIFO empty.
- pause  in  1  downstream almost-full; blocks new pops.
- credit_return  in  1  one-cycle pulse that returns one credit.
- D0_pop  out  1  read strobe to the D0 FIFO (combinational).
- D1_pop  out  1  read strobe to the D1 FIFO (combinational).
- data_out  out  data_width  word to the downstream FIFO (registered).
- wr_enable  out  1  write strobe for data_out (registered).
- credits  out  credit_width  credits currently available.
- idle_out  out  1  state == IDLE (registered).
- active_out  out  1  state == ACTIVE (registered).
- error_out  out  1  state == ERROR (registered).

Behaviour:
- Reset:
  - Sampled on posedge; reset == 0 forces state RESET.
  - All registered outputs, credits, limit, the pipeline and the RR pointer (last = D1, so D0 wins first) go to 0.
  - Pops are 0 while in RESET.
  - A reset mid-operation discards in-flight words; there is no write after the reset edge.
- States: RESET, INIT, IDLE, ACTIVE, ERROR. Transitions are evaluated each posedge:
  - RESET -> INIT on the first edge with reset == 1.
  - INIT:
    - Each cycle, credits <= umbral_credit and limit <= umbral_credit.
    - init == 1 and umbral_credit != 0 -> IDLE.
    - init == 1 and umbral_credit == 0 -> ERROR.
    - init == 0 -> stay in INIT.
  - IDLE -> ACTIVE when !(empty_D0 && empty_D1).
  - ACTIVE -> IDLE when both FIFOs are empty and the pipeline is empty.
  - IDLE/ACTIVE -> ERROR on credit overflow (see below).
  - ERROR is sticky; the only exit is reset. In ERROR: pops 0, wr_enable 0, in-flight words dropped.
  - init is ignored outside INIT.
- Grant (combinational, registered state):
  - Grant requires state == ACTIVE, pause == 0, credits != 0 and the chosen FIFO non-empty.
  - Both FIFOs non-empty: grant the opposite of `last`.
  - Only one non-empty: grant that one.
  - At most one pop per cycle; `last` updates only on a grant.
- Pipeline (fixed latency 2 clocks from pop to write):
  - Pop in cycle N; FIFO data is valid in N+1.
  - In N+1, a stage register records which source was popped.
  - At the N+1 edge: data_out <= selected D*_data and wr_enable <= 1.
  - Both are visible in cycle N+2 for exactly one cycle per word.
  - A new pop every cycle is allowed, giving 1 word/clk sustained.
- Pause:
  - Blocks new pops only.
  - Up to 2 words already popped are still written; the downstream almost-full threshold must reserve 2 entries.
- Credits:
  - Decrement on the edge after a grant.
  - Increment on credit_return.
  - Grant and credit_return in the same cycle leave credits unchanged.
  - Credits never underflow, because a grant requires credits != 0.
  - credit_return while credits == limit and no simultaneous grant is an overflow: next state ERROR and credits hold.
- When idle, data_out holds its last value; wr_enable is 0.

Test Plan:
1. reset = 0 for 4 clocks, then reset = 1, umbral_credit = 3, init = 0 for 2 clocks -> state INIT, credits = 3, all strobes 0; init = 1 -> idle_out = 1 on the next cycle.
2. D0 holds 0x05, 0x0E; D1 holds 0x36, 0x22; credits = 3; no credit_return -> pops D0, D1, D0 on consecutive cycles; wr_enable = 1 two cycles after each pop with data_out = 0x05, 0x36, 0x0E; credits = 0, no further pop.
3. From scenario 2, pulse credit_return once -> D1 popped the next cycle; data_out = 0x22 two cycles later; credits return to 0; active_out -> idle_out once both FIFOs and the pipeline are empty.
4. Both FIFOs full, credits = 15, pause = 1 asserted mid-stream -> exactly 2 more writes, then wr_enable = 0 while paused; pause = 0 -> pops resume with alternation continuing from `last`.
5. Credits at limit 4, credit_return pulse with no grant -> error_out = 1 on the next cycle, pops and writes stay 0 despite non-empty FIFOs; reset = 0 clears to RESET.
6. Simultaneous grant and credit_return at credits = 2 -> credits stay 2. Reset = 0 asserted the cycle after a pop -> no wr_enable ever appears for that word.
